pic_core_param: RTL and testbench

- Parametrised multi-cycle core executing a PIC16-style 14-bit instruction subset; successor to the fixed 8-bit fetch/execute CPU.
- Data width, PC width and RAM depth are parametrised; adds STATUS Z/C flags, literal ops, skip-on-zero ops and a run/stall control.
- Instruction memory is external (async-read ROM); the data register file is internal.
- Sits between the program ROM and the board-level display logic that shows w_q and pc_q.

---
 rtl/pic_core_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_pic_core_param.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_core_param.sv
// pic_core_param: multi-cycle PIC16-style core (T0..T4 sequencer, async-read program ROM, internal register file).
// Build option: define CPU_STACK_EN to add the CALL/RETURN return stack; without it both opcodes are illegal.

module pic_core_param #(
  parameter int DATA_W      = 8,
  parameter int PC_W        = 11,
  parameter int RAM_AW      = 7,
  parameter int STACK_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [13:0]       rom_data,
  output logic [DATA_W-1:0] w_q,
  output logic [PC_W-1:0]   pc_q,
  output logic              z_flag,
  output logic              c_flag,
  output logic              instr_done,
  output logic              illegal
);

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} state_e;
  typedef enum logic [4:0] {
    I_NOP, I_ADDWF, I_SUBWF, I_ANDWF, I_IORWF, I_XORWF, I_COMF, I_DECF, I_INCF, I_MOVF,
    I_DECFSZ, I_INCFSZ, I_CLRF, I_CLRW, I_MOVWF, I_MOVLW, I_ADDLW, I_GOTO, I_CALL, I_RETURN, I_ILL
  } op_e;

  localparam logic [DATA_W-1:0] D_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [PC_W-1:0]   P_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  if (DATA_W < 8 || PC_W < 2 || PC_W > 11 || RAM_AW < 1 || RAM_AW > 7 || STACK_DEPTH < 1) begin : g_bad_cfg
    $error("pic_core_param: unsupported parameter set");
  end

  function automatic op_e decode(input logic [13:0] ins);
    op_e op;
    op = I_ILL;
    casez (ins)
      14'b00_0111_????_????: op = I_ADDWF;
      14'b00_0010_????_????: op = I_SUBWF;
      14'b00_0101_????_????: op = I_ANDWF;
      14'b00_0100_????_????: op = I_IORWF;
      14'b00_0110_????_????: op = I_XORWF;
      14'b00_1001_????_????: op = I_COMF;
      14'b00_0011_????_????: op = I_DECF;
      14'b00_1010_????_????: op = I_INCF;
      14'b00_1000_????_????: op = I_MOVF;
      14'b00_1011_????_????: op = I_DECFSZ;
      14'b00_1111_????_????: op = I_INCFSZ;
      14'b00_0001_1???_????: op = I_CLRF;
      14'b00_0001_0???_????: op = I_CLRW;
      14'b00_0000_1???_????: op = I_MOVWF;
      14'b00_0000_0000_0000: op = I_NOP;
      14'b11_00??_????_????: op = I_MOVLW;
      14'b11_111?_????_????: op = I_ADDLW;
      14'b10_1???_????_????: op = I_GOTO;
`ifdef CPU_STACK_EN
      14'b10_0???_????_????: op = I_CALL;
      14'b00_0000_0000_1000: op = I_RETURN;
`endif
      default:               op = I_ILL;
    endcase
    return op;
  endfunction

  state_e            state_q, state_d;
  logic [PC_W-1:0]   mar_q, mar_d, pc_d;
  logic [13:0]       ir_q, ir_d;
  logic [DATA_W-1:0] w_d;
  logic              z_q, z_d, c_q, c_d, done_q, done_d, ill_q, ill_d;

  logic [DATA_W-1:0] ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] f_addr;
  logic [DATA_W-1:0] f_val, k_val, res;
  logic [DATA_W:0]   sum, diff;
  logic              dsel, wr_w, wr_f, upd_z, skip, ram_we, stack_fault;
  op_e               exec_op, fetch_op;

  assign exec_op  = decode(ir_q);
  assign fetch_op = decode(rom_data);
  assign f_addr   = ir_q[RAM_AW-1:0];
  assign f_val    = ram_q[f_addr];
  assign k_val    = DATA_W'(ir_q[7:0]);

`ifdef CPU_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0] stk_idx;
  logic             stk_we;

  // Overflow and underflow still execute (overwrite top / return to 0) but are flagged.
  assign stack_fault = (fetch_op == I_CALL && sp_q == SP_FULL) || (fetch_op == I_RETURN && sp_q == '0);
`else
  assign stack_fault = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    state_d = state_q;
    mar_d   = mar_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    w_d     = w_q;
    z_d     = z_q;
    c_d     = c_q;
    done_d  = 1'b0;
    ill_d   = 1'b0;
    res     = '0;
    dsel    = 1'b0;
    wr_w    = 1'b0;
    wr_f    = 1'b0;
    upd_z   = 1'b0;
    skip    = 1'b0;
    ram_we  = 1'b0;
    sum     = {1'b0, w_q} + {1'b0, (exec_op == I_ADDLW) ? k_val : f_val};
    diff    = {1'b0, f_val} - {1'b0, w_q};
`ifdef CPU_STACK_EN
    sp_d    = sp_q;
    stk_idx = '0;
    stk_we  = 1'b0;
`endif
    unique case (state_q)
      T0: state_d = T1;
      T1: if (run) begin
        mar_d   = pc_q;
        state_d = T2;
      end
      T2: begin
        pc_d    = pc_q + P_ONE;
        state_d = T3;
      end
      T3: begin
        ir_d    = rom_data;
        done_d  = 1'b1;
        ill_d   = (fetch_op == I_ILL) || stack_fault;
        state_d = T4;
      end
      T4: begin
        case (exec_op)
          I_ADDWF:  begin res = sum[DATA_W-1:0];  c_d = sum[DATA_W];   upd_z = 1'b1; dsel = 1'b1; end
          I_SUBWF:  begin res = diff[DATA_W-1:0]; c_d = ~diff[DATA_W]; upd_z = 1'b1; dsel = 1'b1; end
          I_ANDWF:  begin res = w_q & f_val;      upd_z = 1'b1; dsel = 1'b1; end
          I_IORWF:  begin res = w_q | f_val;      upd_z = 1'b1; dsel = 1'b1; end
          I_XORWF:  begin res = w_q ^ f_val;      upd_z = 1'b1; dsel = 1'b1; end
          I_COMF:   begin res = ~f_val;           upd_z = 1'b1; dsel = 1'b1; end
          I_DECF:   begin res = f_val - D_ONE;    upd_z = 1'b1; dsel = 1'b1; end
          I_INCF:   begin res = f_val + D_ONE;    upd_z = 1'b1; dsel = 1'b1; end
          I_MOVF:   begin res = f_val;            upd_z = 1'b1; dsel = 1'b1; end
          I_DECFSZ: begin res = f_val - D_ONE;    skip = (res == '0); dsel = 1'b1; end
          I_INCFSZ: begin res = f_val + D_ONE;    skip = (res == '0); dsel = 1'b1; end
          I_CLRF:   begin res = '0;               upd_z = 1'b1; wr_f = 1'b1; end
          I_CLRW:   begin res = '0;               upd_z = 1'b1; wr_w = 1'b1; end
          I_MOVWF:  begin res = w_q;              wr_f = 1'b1; end
          I_MOVLW:  begin res = k_val;            wr_w = 1'b1; end
          I_ADDLW:  begin res = sum[DATA_W-1:0];  c_d = sum[DATA_W]; upd_z = 1'b1; wr_w = 1'b1; end
          I_GOTO:   pc_d = ir_q[PC_W-1:0];
`ifdef CPU_STACK_EN
          I_CALL: begin
            stk_we  = 1'b1;
            stk_idx = (sp_q == SP_FULL) ? IDX_W'(STACK_DEPTH - 1) : IDX_W'(sp_q);
            if (sp_q != SP_FULL) sp_d = sp_q + SP_ONE;
            pc_d = ir_q[PC_W-1:0];
          end
          I_RETURN: begin
            if (sp_q == '0) begin
              pc_d = '0;
            end else begin
              stk_idx = IDX_W'(sp_q - SP_ONE);
              sp_d    = sp_q - SP_ONE;
              pc_d    = stack_q[stk_idx];
            end
          end
`endif
          default: ;
        endcase
        if (dsel) begin
          wr_w = ~ir_q[7];
          wr_f = ir_q[7];
        end
        if (wr_w)  w_d = res;
        if (upd_z) z_d = (res == '0);
        if (skip)  pc_d = pc_q + P_ONE;
        ram_we  = wr_f;
        state_d = T1;
      end
      default: state_d = T0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= T0;
      mar_q   <= '0;
      pc_q    <= '0;
      ir_q    <= '0;
      w_q     <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef CPU_STACK_EN
      sp_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      mar_q   <= mar_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      w_q     <= w_d;
      z_q     <= z_d;
      c_q     <= c_d;
      done_q  <= done_d;
      ill_q   <= ill_d;
`ifdef CPU_STACK_EN
      sp_q    <= sp_d;
`endif
    end
  end

  // NOTE: storage arrays carry no reset; software initialises the file and the stack is written before read.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[f_addr] <= res;
  end

`ifdef CPU_STACK_EN
  always_ff @(posedge clk) begin
    if (stk_we) stack_q[stk_idx] <= pc_q;
  end
`endif

  assign rom_addr   = mar_q;
  assign z_flag     = z_q;
  assign c_flag     = c_q;
  assign instr_done = done_q;
  assign illegal    = ill_q;

endmodule

// File: tb/tb_pic_core_param.sv
// Scoreboard bench for pic_core_param: stimulus pushes per-instruction expectations, a monitor pops them on instr_done.
// Build with or without CPU_STACK_EN to match the RTL.

module tb_pic_core_param;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [10:0] rom_addr;
  logic [13:0] rom_data;
  logic [7:0]  w_q;
  logic [10:0] pc_q;
  logic        z_flag, c_flag, instr_done, illegal;

  logic [13:0] rom [2048];
  assign rom_data = rom[rom_addr];

  pic_core_param #(.DATA_W(8), .PC_W(11), .RAM_AW(7), .STACK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .run(run), .rom_addr(rom_addr), .rom_data(rom_data),
    .w_q(w_q), .pc_q(pc_q), .z_flag(z_flag), .c_flag(c_flag),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  w;
    logic [10:0] pc;
    logic        z;
    logic        c;
    logic        ill;
    logic [15:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tag_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic expect_instr(input logic [7:0] w, input logic [10:0] pc, input logic z, input logic c,
                              input logic ill);
    exp_q.push_back('{w: w, pc: pc, z: z, c: c, ill: ill, tag: tag_cnt});
    tag_cnt++;
  endtask

  function automatic logic [13:0] movlw(input logic [7:0] k);  return {6'b110000, k}; endfunction
  function automatic logic [13:0] addlw(input logic [7:0] k);  return {6'b111110, k}; endfunction
  function automatic logic [13:0] movwf(input logic [6:0] f);  return {7'b0000001, f}; endfunction
  function automatic logic [13:0] clrf(input logic [6:0] f);   return {7'b0000011, f}; endfunction
  function automatic logic [13:0] gotoi(input logic [10:0] t); return {3'b101, t}; endfunction
  function automatic logic [13:0] calli(input logic [10:0] t); return {3'b100, t}; endfunction
  function automatic logic [13:0] fop(input logic [5:0] op, input logic d, input logic [6:0] f);
    return {op, d, f};
  endfunction

  localparam logic [13:0] RET  = 14'h0008;
  localparam logic [13:0] CLRW = 14'h0100;
  localparam logic [13:0] BAD  = 14'h0064;

  task automatic clear_rom();
    for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
  endtask

  task automatic hold_reset();
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.delete();
  endtask

  // Runs exactly n instructions, then drops run during the last T4 so the core parks in T1.
  task automatic run_instrs(input int n);
    int seen = 0;
    int gap = 0;
    int budget = 0;
    run = 1'b1;
    while (seen < n && budget < 8 * n + 20) begin
      @(negedge clk);
      budget++;
      gap++;
      if (instr_done) begin
        if (seen > 0) check("done_period", 32'(gap), 32'd4);
        seen++;
        gap = 0;
      end
    end
    if (seen < n) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d of %0d instructions completed", seen, n);
    end
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && instr_done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_instr: instr_done with no expectation, pc 0x%0h", pc_q);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("illegal[%0d]", e.tag), 32'(illegal), 32'(e.ill));
          @(negedge clk);
          check($sformatf("w[%0d]", e.tag),  32'(w_q),    32'(e.w));
          check($sformatf("pc[%0d]", e.tag), 32'(pc_q),   32'(e.pc));
          check($sformatf("z[%0d]", e.tag),  32'(z_flag), 32'(e.z));
          check($sformatf("c[%0d]", e.tag),  32'(c_flag), 32'(e.c));
        end
      end
    end
  end

  initial begin : stimulus
    int dones;

    // Literal ops: MOVLW 05; ADDLW FB -> 0 with Z and C.
    clear_rom();
    rom[0] = movlw(8'h05);
    rom[1] = addlw(8'hFB);
    @(negedge clk);
    check("rst_w", 32'(w_q), 32'h0);
    check("rst_pc", 32'(pc_q), 32'h0);
    check("rst_rom_addr", 32'(rom_addr), 32'h0);
    check("rst_z", 32'(z_flag), 32'h0);
    check("rst_c", 32'(c_flag), 32'h0);
    check("rst_done", 32'(instr_done), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    expect_instr(8'h05, 11'd1, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h00, 11'd2, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    run_instrs(2);
    check("pending_literal", 32'(exp_q.size()), 32'd0);

    // DECFSZ countdown around a GOTO; the third decrement skips the GOTO.
    hold_reset();
    clear_rom();
    rom[0] = movlw(8'h03);
    rom[1] = movwf(7'h10);
    rom[2] = fop(6'b001011, 1'b1, 7'h10);
    rom[3] = gotoi(11'd2);
    rom[4] = fop(6'b001000, 1'b0, 7'h10);
    expect_instr(8'h03, 11'd1, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h03, 11'd2, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h03, 11'd3, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h03, 11'd2, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h03, 11'd3, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h03, 11'd2, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h03, 11'd4, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h00, 11'd5, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    run_instrs(8);
    check("pending_decfsz", 32'(exp_q.size()), 32'd0);

    // ALU sweep on RAM[0x20].
    hold_reset();
    clear_rom();
    rom[0]  = movlw(8'h07);
    rom[1]  = movwf(7'h20);
    rom[2]  = movlw(8'h09);
    rom[3]  = fop(6'b000010, 1'b0, 7'h20);
    rom[4]  = fop(6'b000101, 1'b0, 7'h20);
    rom[5]  = fop(6'b000110, 1'b1, 7'h20);
    rom[6]  = fop(6'b001001, 1'b0, 7'h20);
    rom[7]  = fop(6'b000100, 1'b0, 7'h20);
    rom[8]  = fop(6'b000111, 1'b0, 7'h20);
    rom[9]  = fop(6'b001111, 1'b0, 7'h20);
    rom[10] = fop(6'b000010, 1'b0, 7'h20);
    rom[11] = CLRW;
    rom[12] = fop(6'b000011, 1'b0, 7'h20);
    rom[13] = clrf(7'h20);
    rom[14] = fop(6'b001010, 1'b0, 7'h20);
    expect_instr(8'h07, 11'd1,  1'b0, 1'b0, 1'b0);
    expect_instr(8'h07, 11'd2,  1'b0, 1'b0, 1'b0);
    expect_instr(8'h09, 11'd3,  1'b0, 1'b0, 1'b0);
    expect_instr(8'hFE, 11'd4,  1'b0, 1'b0, 1'b0);
    expect_instr(8'h06, 11'd5,  1'b0, 1'b0, 1'b0);
    expect_instr(8'h06, 11'd6,  1'b0, 1'b0, 1'b0);
    expect_instr(8'hFE, 11'd7,  1'b0, 1'b0, 1'b0);
    expect_instr(8'hFF, 11'd8,  1'b0, 1'b0, 1'b0);
    expect_instr(8'h00, 11'd9,  1'b1, 1'b1, 1'b0);
    expect_instr(8'h02, 11'd10, 1'b1, 1'b1, 1'b0);
    expect_instr(8'hFF, 11'd11, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h00, 11'd12, 1'b1, 1'b0, 1'b0);
    expect_instr(8'h00, 11'd13, 1'b1, 1'b0, 1'b0);
    expect_instr(8'h00, 11'd14, 1'b1, 1'b0, 1'b0);
    expect_instr(8'h01, 11'd15, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run_instrs(15);
    check("pending_alu", 32'(exp_q.size()), 32'd0);

    // Stall: run low for 10 cycles after the first instruction.
    hold_reset();
    clear_rom();
    rom[0] = movlw(8'h11);
    rom[1] = movlw(8'h22);
    rom[2] = movlw(8'h33);
    expect_instr(8'h11, 11'd1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run_instrs(1);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (instr_done) dones++;
    end
    check("stall_pc", 32'(pc_q), 32'd1);
    check("stall_rom_addr", 32'(rom_addr), 32'd0);
    check("stall_done_count", 32'(dones), 32'd0);
    expect_instr(8'h22, 11'd2, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h33, 11'd3, 1'b0, 1'b0, 1'b0);
    run_instrs(2);
    check("pending_stall", 32'(exp_q.size()), 32'd0);

    // Reset asserted in T3 of an ADDWF aborts it; execution restarts at 0.
    hold_reset();
    clear_rom();
    rom[0] = movlw(8'h05);
    rom[1] = movwf(7'h20);
    rom[2] = fop(6'b000111, 1'b0, 7'h20);
    expect_instr(8'h05, 11'd1, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h05, 11'd2, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run_instrs(2);
    run = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_pc_before", 32'(pc_q), 32'd3);
    check("abort_w_before", 32'(w_q), 32'h05);
    reset = 1'b0;
    #1;
    check("abort_w", 32'(w_q), 32'h0);
    check("abort_pc", 32'(pc_q), 32'h0);
    check("abort_rom_addr", 32'(rom_addr), 32'h0);
    run = 1'b0;
    check("pending_abort", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    expect_instr(8'h05, 11'd1, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h05, 11'd2, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h0A, 11'd3, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    run_instrs(3);
    check("pending_restart", 32'(exp_q.size()), 32'd0);

    // CALL/RETURN image; RETURN at 7 is a pop on an empty stack (or undecoded without the stack).
    hold_reset();
    clear_rom();
    rom[4]      = calli(11'h100);
    rom[5]      = movlw(8'h5A);
    rom[6]      = BAD;
    rom[7]      = RET;
    rom[11'h100] = RET;
    for (int i = 1; i <= 4; i++) expect_instr(8'h00, 11'(i), 1'b0, 1'b0, 1'b0);
`ifdef CPU_STACK_EN
    expect_instr(8'h00, 11'h100, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h00, 11'h005, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h5A, 11'h006, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h5A, 11'h007, 1'b0, 1'b0, 1'b1);
    expect_instr(8'h5A, 11'h000, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    run_instrs(9);
`else
    expect_instr(8'h00, 11'h005, 1'b0, 1'b0, 1'b1);
    expect_instr(8'h5A, 11'h006, 1'b0, 1'b0, 1'b0);
    expect_instr(8'h5A, 11'h007, 1'b0, 1'b0, 1'b1);
    expect_instr(8'h5A, 11'h008, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    run_instrs(8);
`endif
    check("pending_stack", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
